// File: rtl/word_breaker.sv
// Pops words from a first-word-fall-through FIFO and streams them out as bytes
// over a valid/ready handshake, fetching the next word back-to-back when available.
module word_breaker #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BYTE_SIZE = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_r_enable,
  output logic [BYTE_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy
);

  localparam int unsigned NUM_BYTES = WORD_SIZE / BYTE_SIZE;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [WORD_SIZE-1:0] word_q;
  logic [WORD_SIZE-1:0] word_d;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_d;
  logic [IDX_W-1:0]     sel;
  logic                 last;
  logic [BYTE_SIZE-1:0] byte_lane [NUM_BYTES];

  // Byte lanes of the held word, lane 0 = least significant byte
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    assign byte_lane[i] = word_q[i*BYTE_SIZE +: BYTE_SIZE];
  end

  assign sel      = LSB_FIRST ? idx : (LAST_IDX - idx);
  assign tx_data  = byte_lane[sel];
  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND);

  // Next-state, word capture and pop strobe
  always_comb begin
    state_d       = state;
    word_d        = word_q;
    idx_d         = idx;
    fifo_r_enable = 1'b0;
    last          = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_r_enable = 1'b1;
          word_d        = fifo_data;
          idx_d         = '0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (!last) begin
            idx_d = idx + IDX_W'(1);
          end else if (!fifo_empty) begin
            fifo_r_enable = 1'b1;
            word_d        = fifo_data;
            idx_d         = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // No pop may escape while reset is held, even though the state already reads IDLE
    if (!reset) begin
      fifo_r_enable = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      word_q <= '0;
      idx    <= '0;
    end else begin
      state  <= state_d;
      word_q <= word_d;
      idx    <= idx_d;
    end
  end

endmodule

// File: tb/tb_word_breaker.sv
// Bench for word_breaker: a FIFO model plus a byte-queue reference drive two
// instances (LSB-first and MSB-first) that are compared every cycle.
module tb_word_breaker;

  logic        clock = 1'b0;
  logic        reset;
  logic        tx_ready;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data  = 32'h0;
  logic        ren_l, ren_m, val_l, val_m, busy_l, busy_m;
  logic [7:0]  data_l, data_m;

  logic [31:0] fq[$];
  logic [7:0]  pend_l[$];
  logic [7:0]  pend_m[$];
  logic [7:0]  got_l[$];
  logic [7:0]  got_m[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_m[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;

  word_breaker #(.WORD_SIZE(32), .BYTE_SIZE(8), .LSB_FIRST(1'b1)) dut_l (
    .clock(clock), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_r_enable(ren_l), .tx_data(data_l), .tx_valid(val_l), .tx_ready(tx_ready),
    .busy(busy_l)
  );

  word_breaker #(.WORD_SIZE(32), .BYTE_SIZE(8), .LSB_FIRST(1'b0)) dut_m (
    .clock(clock), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_r_enable(ren_m), .tx_data(data_m), .tx_valid(val_m), .tx_ready(tx_ready),
    .busy(busy_m)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] q[$], input int base,
                           input logic [7:0] e[$]);
    check({name, "_len"}, 32'(q.size() - base), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (base + i < q.size()) check(name, 32'(q[base+i]), 32'(e[i]));
    end
  endtask

  // FIFO model: pops on the strobe seen at the edge, flags settle 1 after the edge
  always begin
    @(posedge clock);
    if (ren_l) begin
      n_pops++;
      check("no_underflow", 32'(fq.size() > 0), 32'h1);
      if (fq.size() > 0) void'(fq.pop_front());
    end
    #1;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 32'h0 : fq[0];
  end

  // Reference: a popped word becomes four pending bytes; a handshake consumes the head
  always @(posedge clock) begin
    if (!reset) begin
      pend_l.delete();
      pend_m.delete();
    end else begin
      bit take;
      take = !fifo_empty && (pend_l.size() == 0 || (pend_l.size() == 1 && tx_ready));
      if (pend_l.size() > 0 && tx_ready) begin
        void'(pend_l.pop_front());
        void'(pend_m.pop_front());
      end
      if (take) begin
        for (int k = 0; k < 4; k++) begin
          pend_l.push_back(8'(fifo_data >> (8 * k)));
          pend_m.push_back(8'(fifo_data >> (8 * (3 - k))));
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the reference
  always begin
    logic exp_val, exp_ren;
    @(negedge clock);
    #2;
    exp_val = reset && (pend_l.size() > 0);
    exp_ren = reset && !fifo_empty &&
              (pend_l.size() == 0 || (pend_l.size() == 1 && tx_ready));
    check("ren_l", 32'(ren_l), 32'(exp_ren));
    check("ren_m", 32'(ren_m), 32'(exp_ren));
    check("valid_l", 32'(val_l), 32'(exp_val));
    check("valid_m", 32'(val_m), 32'(exp_val));
    check("busy_l", 32'(busy_l), 32'(exp_val));
    check("busy_m", 32'(busy_m), 32'(exp_val));
    if (!reset) begin
      check("rst_data_l", 32'(data_l), 32'h0);
      check("rst_data_m", 32'(data_m), 32'h0);
    end else if (pend_l.size() > 0) begin
      check("data_l", 32'(data_l), 32'(pend_l[0]));
      check("data_m", 32'(data_m), 32'(pend_m[0]));
    end
    if (val_l && tx_ready) got_l.push_back(data_l);
    if (val_m && tx_ready) got_m.push_back(data_m);
  end

  task automatic cyc(input logic rdy);
    @(negedge clock);
    tx_ready = rdy;
    #3;
  endtask

  initial begin
    int base_l, base_m, pops0;
    reset    = 1'b1;
    tx_ready = 1'b0;
    #1 reset = 1'b0;

    // Reset held with a non-empty FIFO: nothing may move
    fq.push_back(32'hDEADBEEF);
    repeat (4) begin
      cyc(1'b1);
      check("rst_ren", 32'(ren_l), 32'h0);
      check("rst_valid", 32'(val_l), 32'h0);
      check("rst_data", 32'(data_l), 32'h0);
      check("rst_busy", 32'(busy_l), 32'h0);
    end
    check("rst_fifo_kept", 32'(fq.size()), 32'h1);
    fq.delete();
    cyc(1'b0);
    reset = 1'b1;
    cyc(1'b1);
    check("idle_valid", 32'(val_l), 32'h0);

    // Single word, both byte orders
    base_l = got_l.size(); base_m = got_m.size(); pops0 = n_pops;
    fq.push_back(32'h11223344);
    cyc(1'b1);
    check("t1_pop", 32'(ren_l), 32'h1);
    check("t1_not_yet_valid", 32'(val_l), 32'h0);
    exp_q = {8'h44, 8'h33, 8'h22, 8'h11};
    exp_m = {8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      check("t1_valid", 32'(val_l), 32'h1);
      check("t1_byte_lsb", 32'(data_l), 32'(exp_q[i]));
      check("t1_byte_msb", 32'(data_m), 32'(exp_m[i]));
    end
    cyc(1'b1);
    check("t1_idle_after", 32'(val_l), 32'h0);
    check("t1_pops", 32'(n_pops - pops0), 32'h1);
    check_seq("t1_seq_lsb", got_l, base_l, exp_q);
    check_seq("t1_seq_msb", got_m, base_m, exp_m);

    // Back-pressure on byte 1
    base_l = got_l.size(); pops0 = n_pops;
    fq.push_back(32'hA1B2C3D4);
    cyc(1'b1);
    cyc(1'b1);
    check("bp_byte0", 32'(data_l), 32'hD4);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      check("bp_hold_data", 32'(data_l), 32'hC3);
      check("bp_hold_valid", 32'(val_l), 32'h1);
    end
    repeat (4) cyc(1'b1);
    check("bp_idle_after", 32'(val_l), 32'h0);
    check("bp_pops", 32'(n_pops - pops0), 32'h1);
    exp_q = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check_seq("bp_seq", got_l, base_l, exp_q);

    // Back-to-back words, no bubble
    base_l = got_l.size(); base_m = got_m.size(); pops0 = n_pops;
    fq.push_back(32'h00000001);
    fq.push_back(32'h00000002);
    cyc(1'b1);
    check("b2b_pop0", 32'(ren_l), 32'h1);
    exp_q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    exp_m = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1);
      check("b2b_valid", 32'(val_l), 32'h1);
      check("b2b_byte", 32'(data_l), 32'(exp_q[i]));
      check("b2b_pop_at_4", 32'(ren_l), 32'(i == 3));
    end
    cyc(1'b1);
    check("b2b_idle_after", 32'(val_l), 32'h0);
    check("b2b_pops", 32'(n_pops - pops0), 32'h2);
    check_seq("b2b_seq_lsb", got_l, base_l, exp_q);
    check_seq("b2b_seq_msb", got_m, base_m, exp_m);

    // Reset in the middle of a word drops the rest of it
    base_l = got_l.size(); pops0 = n_pops;
    fq.push_back(32'hCAFEF00D);
    fq.push_back(32'h55667788);
    cyc(1'b1);
    cyc(1'b1);
    check("mr_byte0", 32'(data_l), 32'h0D);
    cyc(1'b1);
    check("mr_byte1", 32'(data_l), 32'hF0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mr_valid_drop", 32'(val_l), 32'h0);
    check("mr_busy_drop", 32'(busy_l), 32'h0);
    check("mr_data_clear", 32'(data_l), 32'h0);
    cyc(1'b1);
    check("mr_no_pop", 32'(ren_l), 32'h0);
    cyc(1'b1);
    reset = 1'b1;
    #1;
    check("mr_pop_on_release", 32'(ren_l), 32'h1);
    exp_q = {8'h88, 8'h77, 8'h66, 8'h55};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      check("mr_next_word", 32'(data_l), 32'(exp_q[i]));
    end
    cyc(1'b1);
    check("mr_idle_after", 32'(val_l), 32'h0);
    check("mr_pops", 32'(n_pops - pops0), 32'h2);
    exp_q = {8'h0D, 8'hF0, 8'h88, 8'h77, 8'h66, 8'h55};
    check_seq("mr_seq", got_l, base_l, exp_q);

    repeat (3) cyc(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
